// File: rtl/riscv_pkg.sv
// Shared definitions for the program loader: FSM state encoding, stream framing
// constants and a state decode helper.
package riscv_pkg;

   localparam int unsigned LEN_BYTES  = 2;
   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned WORD_W     = 8 * WORD_BYTES;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      CHK,
      RUN,
      ERR
   } loader_state_t;

   // States in which the loader accepts bytes from the stream
   function automatic logic takes_bytes(input loader_state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHK);
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects stream bytes into little-endian instruction words; word_ready_c pulses
// combinationally with the byte that completes a word.
module byte_packer
   import riscv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              en,
   input  logic [7:0]        data,
   output logic              word_ready_c,
   output logic [WORD_W-1:0] word_c
);

   localparam int unsigned CNT_W   = $clog2(WORD_BYTES);
   localparam int unsigned SHIFT_W = WORD_W - 8;

   logic [CNT_W-1:0]   cnt;
   logic [SHIFT_W-1:0] shift;

   // Earlier bytes slide toward the LSB so the first byte ends up in [7:0]
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         cnt   <= '0;
         shift <= '0;
      end else if (en) begin
         cnt   <= cnt + CNT_W'(1);
         shift <= {data, shift[SHIFT_W-1:8]};
      end
   end

   assign word_ready_c = en && (cnt == CNT_W'(WORD_BYTES - 1));
   assign word_c       = {data, shift};

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program image into instruction memory and then releases
// the core. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              done,
   output logic              err
);

   localparam int unsigned CNT_W     = ADDR_W + 1;
   localparam int unsigned LEN_W     = 8 * LEN_BYTES;
   localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_t POST_LOAD = CHK;
`else
   localparam loader_state_t POST_LOAD = RUN;
`endif

   loader_state_t     state;
   loader_state_t     state_nxt;
   logic [LEN_W-1:0]  len;
   logic [CNT_W-1:0]  word_idx;
   logic [LEN_W-1:0]  len_full_c;
   logic              take_c;
   logic              restart_c;
   logic              pack_en_c;
   logic              last_word_c;
   logic              word_ready_c;
   logic [WORD_W-1:0] word_c;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   assign take_c      = in_valid && in_ready;
   assign restart_c   = start && ((state == IDLE) || (state == RUN) || (state == ERR));
   assign pack_en_c   = take_c && (state == DATA);
   assign len_full_c  = {in_data, len[7:0]};
   assign last_word_c = (32'(word_idx) + 32'd1) == 32'(len);

   byte_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .clear        (restart_c),
      .en           (pack_en_c),
      .data         (in_data),
      .word_ready_c (word_ready_c),
      .word_c       (word_c)
   );

   // Next-state decode
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (start) state_nxt = LEN_LO;
         LEN_LO: if (take_c) state_nxt = LEN_HI;
         LEN_HI: begin
            if (take_c) begin
               if (32'(len_full_c) > MAX_WORDS)  state_nxt = ERR;
               else if (len_full_c == '0)        state_nxt = POST_LOAD;
               else                              state_nxt = DATA;
            end
         end
         DATA:   if (word_ready_c) state_nxt = WRITE;
         WRITE:  state_nxt = last_word_c ? POST_LOAD : DATA;
`ifdef LOADER_CHECKSUM_EN
         CHK:    if (take_c) state_nxt = (in_data == csum) ? RUN : ERR;
`else
         CHK:    state_nxt = IDLE;
`endif
         RUN:    if (start) state_nxt = LEN_LO;
         ERR:    if (start) state_nxt = LEN_LO;
      endcase
   end

   // State, datapath and registered outputs decoded from the state being entered
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_reset <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         len        <= '0;
         word_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         state      <= state_nxt;
         in_ready   <= takes_bytes(state_nxt);
         imem_we    <= (state_nxt == WRITE);
         core_reset <= (state_nxt != RUN);
         done       <= (state_nxt == RUN);
         err        <= (state_nxt == ERR);

         if (state_nxt == WRITE) begin
            imem_addr  <= word_idx[ADDR_W-1:0];
            imem_wdata <= word_c;
         end

         if (restart_c) begin
            len      <= '0;
            word_idx <= '0;
         end
         if (take_c && (state == LEN_LO)) len[7:0]  <= in_data;
         if (take_c && (state == LEN_HI)) len[15:8] <= in_data;
         if (state == WRITE) word_idx <= word_idx + CNT_W'(1);

`ifdef LOADER_CHECKSUM_EN
         if (restart_c)      csum <= '0;
         else if (pack_en_c) csum <= csum ^ in_data;
`endif
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader (default width plus an ADDR_W=4
// instance for the overflow and full-capacity boundaries).
module tb_program_loader;

`ifdef LOADER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam int NV = 4 + CS;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;

   logic        rdy, we, crst, done, err;
   logic [9:0]  addr;
   logic [31:0] wdata;
   logic        rdy4, we4, crst4, done4, err4;
   logic [3:0]  addr4;
   logic [31:0] wdata4;

   program_loader dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy), .imem_we(we), .imem_addr(addr), .imem_wdata(wdata),
      .core_reset(crst), .done(done), .err(err)
   );

   program_loader #(.ADDR_W(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy4), .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
      .core_reset(crst4), .done(done4), .err(err4)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      string       name;
      bit          gap;
      int          nb;
      int          nwr;
      logic [31:0] w0;
      logic [31:0] w1;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   wr_t  wq[$];
   wr_t  wq4[$];
   wr_t  tmp;
   int   dbl_we, dbl_we4;
   logic we_prev, we4_prev;
   int   n_cmp = 0;
   int   n_fail = 0;

   vec_t       vec [5];
   logic [7:0] vb  [5][12];
   logic [31:0] exp4 [16];

   // Write monitor: one record per cycle that a strobe is high
   always @(negedge clk) begin
      if (we === 1'b1) begin
         tmp.addr = addr;
         tmp.data = wdata;
         wq.push_back(tmp);
         if (we_prev === 1'b1) dbl_we++;
      end
      if (we4 === 1'b1) begin
         tmp.addr = {6'd0, addr4};
         tmp.data = wdata4;
         wq4.push_back(tmp);
         if (we4_prev === 1'b1) dbl_we4++;
      end
      we_prev  = we;
      we4_prev = we4;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic fail_timeout(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no response within cycle budget, want response", nm);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wq.delete();
      wq4.delete();
      dbl_we = 0;
      dbl_we4 = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap, input bit use4);
      int w = 0;
      if (gap) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      while (((use4 ? rdy4 : rdy) !== 1'b1) && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (w >= 20) fail_timeout("in_ready_wait");
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_end(input bit use4, input string nm);
      int w = 0;
      while (((use4 ? (done4 | err4) : (done | err)) !== 1'b1) && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (w >= 40) fail_timeout(nm);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] cs4;

      vec[0] = '{"basic",     1'b0, 10 + CS, 2, 32'h00000013, 32'h00100093, 1'b1, 1'b0};
      vec[1] = '{"gapped",    1'b1, 10 + CS, 2, 32'h00000013, 32'h00100093, 1'b1, 1'b0};
      vec[2] = '{"zero_len",  1'b0,  2 + CS, 0, 32'h0,        32'h0,        1'b1, 1'b0};
      vec[3] = '{"one_word",  1'b1,  6 + CS, 1, 32'h12345678, 32'h0,        1'b1, 1'b0};
      vec[4] = '{"bad_csum",  1'b0,  6 + CS, 1, 32'h12345678, 32'h0,        1'b0, 1'b1};
      vb[0] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90, 8'h00};
      vb[1] = vb[0];
      vb[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vb[3] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vb[4] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      reset = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      dbl_we = 0;
      dbl_we4 = 0;

      // Reset values after two low cycles
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(rdy), 64'd0);
      chk("rst_imem_we", 64'(we), 64'd0);
      chk("rst_imem_addr", 64'(addr), 64'd0);
      chk("rst_core_reset", 64'(crst), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst4_core_reset", 64'(crst4), 64'd1);
      reset = 1'b1;

      for (int v = 0; v < NV; v++) begin
         do_reset();
         pulse_start();
         for (int i = 0; i < vec[v].nb; i++) send_byte(vb[v][i], vec[v].gap, 1'b0);
         wait_end(1'b0, {vec[v].name, "_end"});
         chk({vec[v].name, "_nwr"}, 64'(wq.size()), 64'(vec[v].nwr));
         if (vec[v].nwr >= 1 && wq.size() >= 1)
            chk({vec[v].name, "_w0"}, 64'(wq[0]), {22'd0, 10'd0, vec[v].w0});
         if (vec[v].nwr >= 2 && wq.size() >= 2)
            chk({vec[v].name, "_w1"}, 64'(wq[1]), {22'd0, 10'd1, vec[v].w1});
         chk({vec[v].name, "_done"}, 64'(done), 64'(vec[v].exp_done));
         chk({vec[v].name, "_err"}, 64'(err), 64'(vec[v].exp_err));
         chk({vec[v].name, "_core_reset"}, 64'(crst), 64'(!vec[v].exp_done));
         chk({vec[v].name, "_we_one_cycle"}, 64'(dbl_we), 64'd0);
      end

      // Restart from RUN clears done and raises core_reset on the start edge
      do_reset();
      pulse_start();
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      if (CS == 1) send_byte(8'h00, 1'b0, 1'b0);
      wait_end(1'b0, "restart_end");
      chk("restart_pre_done", 64'(done), 64'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_done", 64'(done), 64'd0);
      chk("restart_core_reset", 64'(crst), 64'd1);
      chk("restart_in_ready", 64'(rdy), 64'd1);

      // start during DATA is ignored
      do_reset();
      pulse_start();
      send_byte(8'h01, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h78, 1'b0, 1'b0);
      pulse_start();
      send_byte(8'h56, 1'b0, 1'b0);
      send_byte(8'h34, 1'b0, 1'b0);
      send_byte(8'h12, 1'b0, 1'b0);
      if (CS == 1) send_byte(8'h08, 1'b0, 1'b0);
      wait_end(1'b0, "ign_start_end");
      chk("ign_start_nwr", 64'(wq.size()), 64'd1);
      chk("ign_start_done", 64'(done), 64'd1);

      // Reset after five data bytes aborts the load
      do_reset();
      pulse_start();
      for (int i = 0; i < 7; i++) send_byte(vb[0][i], 1'b0, 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_in_ready", 64'(rdy), 64'd0);
      chk("abort_core_reset", 64'(crst), 64'd1);
      chk("abort_done", 64'(done), 64'd0);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_nwr", 64'(wq.size()), 64'd1);
      if (wq.size() >= 1) chk("abort_w0", 64'(wq[0]), {22'd0, 10'd0, 32'h00000013});
      chk("abort_idle_in_ready", 64'(rdy), 64'd0);

      // ADDR_W=4: N=17 overflows
      do_reset();
      pulse_start();
      send_byte(8'h11, 1'b0, 1'b1);
      send_byte(8'h00, 1'b0, 1'b1);
      wait_end(1'b1, "ovf_end");
      chk("ovf_err", 64'(err4), 64'd1);
      chk("ovf_done", 64'(done4), 64'd0);
      chk("ovf_core_reset", 64'(crst4), 64'd1);
      chk("ovf_nwr", 64'(wq4.size()), 64'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ovf_restart_err", 64'(err4), 64'd0);
      chk("ovf_restart_in_ready", 64'(rdy4), 64'd1);

      // ADDR_W=4: N=16 fills memory exactly, last address 15
      do_reset();
      pulse_start();
      send_byte(8'h10, 1'b0, 1'b1);
      send_byte(8'h00, 1'b0, 1'b1);
      cs4 = 8'h00;
      for (int w = 0; w < 16; w++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(w * 4 + k);
            cs4 = cs4 ^ b;
            exp4[w][8*k +: 8] = b;
            send_byte(b, 1'b0, 1'b1);
         end
      end
      if (CS == 1) send_byte(cs4, 1'b0, 1'b1);
      wait_end(1'b1, "full_end");
      chk("full_done", 64'(done4), 64'd1);
      chk("full_core_reset", 64'(crst4), 64'd0);
      chk("full_nwr", 64'(wq4.size()), 64'd16);
      chk("full_we_one_cycle", 64'(dbl_we4), 64'd0);
      for (int w = 0; w < 16; w++)
         if (w < wq4.size()) chk($sformatf("full_w%0d", w), 64'(wq4[w]), {22'd0, 10'(w), exp4[w]});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
